// File: rtl/pe_array_out_axis_pkg.sv
// pe_array_out_axis_pkg: shared defaults and sizing helper for the PE-array output stage
package pe_array_out_axis_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int FRAME_LEN = 512;
  localparam int CNT_W = 16;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pe_array_out_axis_if.sv
// pe_array_out_axis_if: AXI-Stream style word channel toward the DMA/host
interface pe_array_out_axis_if
  import pe_array_out_axis_pkg::*;
#(
  parameter int DW = DATA_WIDTH * 2
) ();
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [DW-1:0] tdata;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/pe_array_out_axis_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO with extra-MSB pointers and occupancy level
module sync_fifo_fwft
  import pe_array_out_axis_pkg::*;
#(
  parameter int W = 33,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rd = rd_en & ~empty;
  assign wr = wr_en & (~full | rd);
  // head word is visible combinationally; zeroed while empty so idle output is clean
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/pe_array_out_axis.sv
// pe_array_out_axis: buffers the PE-array result stream and re-emits it as AXIS with frame TLAST
module pe_array_out_axis
  import pe_array_out_axis_pkg::*;
#(
  parameter int DATA_WIDTH = pe_array_out_axis_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = pe_array_out_axis_pkg::FIFO_DEPTH,
  parameter int FRAME_LEN = pe_array_out_axis_pkg::FRAME_LEN,
  parameter int CNT_W = pe_array_out_axis_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_v,
  input  logic [DATA_WIDTH*2-1:0]       din,
  input  logic                          clr_ovf,
  pe_array_out_axis_if.master           m,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic [CNT_W-1:0]              frame_cnt
);
  localparam int DW = DATA_WIDTH * 2;
  localparam int BW = clog2_min1(FRAME_LEN);
  logic [BW-1:0] beat;
  logic [DW:0] rd_word;
  logic full, empty, pop, push, drop, tag_last;
  assign pop = m.tvalid & m.tready;
  assign push = din_v & (~full | pop);
  assign drop = din_v & full & ~pop;
  assign tag_last = beat == BW'(FRAME_LEN - 1);
  assign m.tvalid = ~empty;
  assign m.tlast = rd_word[DW];
  assign m.tdata = rd_word[DW-1:0];
  sync_fifo_fwft #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data({tag_last, din}),
    .rd_en(pop),
    .rd_data(rd_word),
    .full(full),
    .empty(empty),
    .level(level)
  );
  // beat counts dropped words too, keeping TLAST aligned with the array's frames
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
      ovf <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (din_v) beat <= tag_last ? '0 : beat + BW'(1);
      ovf <= drop | (ovf & ~clr_ovf);
      frame_cnt <= frame_cnt + CNT_W'(pop & m.tlast);
    end
  end
endmodule

// File: tb/tb_pe_array_out_axis.sv
// tb_pe_array_out_axis: random and directed stimulus against a queue-based reference model
module tb_pe_array_out_axis;
  localparam int DEPTH = 8;
  localparam int FL = 8;
  logic clk = 0, rst = 1, din_v = 0, clr_ovf = 0;
  logic [31:0] din = 0;
  logic [3:0] level;
  logic ovf;
  logic [15:0] frame_cnt;
  int n_chk = 0, n_fail = 0;
  typedef struct {bit last; logic [31:0] data;} ent_t;
  ent_t q[$];
  int m_beat = 0, m_fc = 0;
  bit m_ovf = 0;
  pe_array_out_axis_if #(.DW(32)) axis ();
  pe_array_out_axis #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din_v(din_v), .din(din), .clr_ovf(clr_ovf),
    .m(axis), .level(level), .ovf(ovf), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: a bounded queue of (last, data); beats advance on every valid input
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_beat <= 0;
      m_ovf <= 0;
      m_fc <= 0;
    end else begin
      automatic bit was_full = q.size() == DEPTH;
      automatic bit popped = q.size() != 0 && axis.tready;
      automatic bit dropped = din_v && was_full && !popped;
      if (popped) begin
        if (q[0].last) m_fc <= (m_fc + 1) % 65536;
        void'(q.pop_front());
      end
      if (din_v && !dropped) q.push_back('{last: m_beat == FL - 1, data: din});
      if (din_v) m_beat <= (m_beat + 1) % FL;
      m_ovf <= dropped ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
    end
  end
  always @(negedge clk) begin
    chk("tvalid", axis.tvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk("tdata", axis.tdata, q[0].data);
      chk("tlast", axis.tlast, q[0].last);
    end
    chk("level", level, q.size());
    chk("ovf", ovf, m_ovf);
    chk("frame_cnt", frame_cnt, m_fc);
  end
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
    @(negedge clk);
    din_v = v;
    din = d;
    axis.tready = r;
    clr_ovf = c;
  endtask
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask
  initial begin
    axis.tready = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    drive(1, 32'h1, 1, 0);
    after_edge();
    chk("fwft_valid", axis.tvalid, 1);
    chk("fwft_data", axis.tdata, 32'h1);
    for (int i = 2; i <= 16; i++) drive(1, 32'(i), 1, 0);
    repeat (2) drive(0, 0, 1, 0);
    after_edge();
    chk("pass_frames", frame_cnt, 2);
    chk("pass_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) drive(1, 32'h100 + 32'(i), 0, 0);
    after_edge();
    chk("bp_level", level, 8);
    chk("bp_ovf", ovf, 0);
    repeat (3) drive(0, 0, 0, 0);
    chk("bp_hold", axis.tdata, 32'h100);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0);
    after_edge();
    chk("bp_drained", level, 0);
    chk("bp_frames", frame_cnt, 3);
    for (int i = 0; i < 10; i++) drive(1, 32'h200 + 32'(i), 0, 0);
    after_edge();
    chk("ovf_level", level, 8);
    chk("ovf_set", ovf, 1);
    drive(0, 0, 0, 1);
    after_edge();
    chk("ovf_clr", ovf, 0);
    drive(1, 32'h2aa, 1, 0);
    after_edge();
    chk("fullpop_level", level, 8);
    chk("fullpop_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) drive(1, 32'h300 + 32'(i), 1, 0);
    repeat (12) drive(0, 0, 1, 0);
    after_edge();
    chk("align_frames", frame_cnt, 5);
    for (int i = 0; i < 5; i++) drive(1, 32'h400 + 32'(i), 1, 0);
    @(negedge clk);
    rst = 1;
    din_v = 0;
    @(negedge clk);
    rst = 0;
    chk("midrst_tvalid", axis.tvalid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_frames", frame_cnt, 0);
    for (int i = 0; i < 8; i++) drive(1, 32'h500 + 32'(i), 1, 0);
    repeat (2) drive(0, 0, 1, 0);
    after_edge();
    chk("midrst_frame", frame_cnt, 1);
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    repeat (20) drive(0, 0, 1, 0);
    after_edge();
    chk("rand_drained", level, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
